// File: rtl/score_sequencer.sv
// Game score/lives sequencer with high-score commit and display scan strobe.
// Optional new-high flash blanking is built when NEW_HIGH_FLASH_EN is defined.
module score_sequencer #(
   parameter int SCAN_DIV  = 100000,
   parameter int SCORE_MAX = 9999,
   parameter int LIVES     = 3,
   parameter int FLASH_DIV = 250
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_game_start,
   input  logic        i_brick_hit,
   input  logic [3:0]  i_hit_points,
   input  logic        i_ball_lost,
   output logic [13:0] o_current_score,
   output logic [13:0] o_high_score,
   output logic [1:0]  o_lives_left,
   output logic        o_game_active,
   output logic        o_game_over,
   output logic        o_new_high,
   output logic        o_scan_tick,
   output logic        o_flash_blank
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PLAY   = 2'd1;
   localparam logic [1:0] S_COMMIT = 2'd2;
   localparam logic [1:0] S_OVER   = 2'd3;

   localparam int             SCW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
   localparam logic [SCW-1:0] TICK_PRE  = SCW'((SCAN_DIV > 1) ? SCAN_DIV - 2 : 0);
   localparam logic [14:0]    MAX15     = 15'(SCORE_MAX);
   localparam logic [1:0]     LIVES2    = 2'(LIVES);

   logic [1:0]     r_state, w_next;
   logic [13:0]    r_score, r_high;
   logic [1:0]     r_lives;
   logic           r_active, r_over, r_new_high;
   logic [SCW-1:0] r_scan_cnt;
   logic           r_scan_tick;
   logic [14:0]    w_sum;
   logic [13:0]    w_clamped;

   // 15-bit sum so the clamp sees the true overflow past SCORE_MAX
   assign w_sum     = {1'b0, r_score} + {11'd0, i_hit_points};
   assign w_clamped = (w_sum > MAX15) ? MAX15[13:0] : w_sum[13:0];

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_OVER: if (i_game_start) w_next = S_PLAY;
         S_PLAY:         if (i_ball_lost && r_lives == 2'd1) w_next = S_COMMIT;
         S_COMMIT:       w_next = S_OVER;
         default:        w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= S_IDLE;
         r_score    <= '0;
         r_high     <= '0;
         r_lives    <= LIVES2;
         r_active   <= 1'b0;
         r_over     <= 1'b0;
         r_new_high <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_active <= (w_next == S_PLAY);
         r_over   <= (w_next == S_OVER);
         case (r_state)
            S_IDLE, S_OVER: begin
               if (i_game_start) begin
                  r_score    <= '0;
                  r_lives    <= LIVES2;
                  r_new_high <= 1'b0;
               end
            end
            S_PLAY: begin
               if (i_brick_hit) r_score <= w_clamped;
               if (i_ball_lost) r_lives <= r_lives - 2'd1;
            end
            S_COMMIT: begin
               if (r_score > r_high) begin
                  r_high     <= r_score;
                  r_new_high <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Tick is registered one count early so it lines up with counter == SCAN_DIV-1
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_scan_cnt  <= '0;
         r_scan_tick <= 1'b0;
      end else begin
         r_scan_cnt  <= (r_scan_cnt == SCAN_LAST) ? '0 : r_scan_cnt + 1'b1;
         r_scan_tick <= (r_scan_cnt == TICK_PRE);
      end
   end

`ifdef NEW_HIGH_FLASH_EN
   localparam int             FCW        = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
   localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_DIV - 1);

   logic [FCW-1:0] r_flash_cnt;
   logic           r_flash;

   always_ff @(posedge i_clk) begin
      if (i_reset || r_state != S_OVER || w_next != S_OVER) begin
         r_flash_cnt <= '0;
         r_flash     <= 1'b0;
      end else if (r_new_high && r_scan_tick) begin
         if (r_flash_cnt == FLASH_LAST) begin
            r_flash_cnt <= '0;
            r_flash     <= ~r_flash;
         end else begin
            r_flash_cnt <= r_flash_cnt + 1'b1;
         end
      end
   end

   assign o_flash_blank = r_flash;
`else
   assign o_flash_blank = 1'b0;
`endif

   assign o_current_score = r_score;
   assign o_high_score    = r_high;
   assign o_lives_left    = r_lives;
   assign o_game_active   = r_active;
   assign o_game_over     = r_over;
   assign o_new_high      = r_new_high;
   assign o_scan_tick     = r_scan_tick;

endmodule

// File: tb/tb_score_sequencer.sv
// Directed bench for score_sequencer (SCAN_DIV=4, FLASH_DIV=2, LIVES=3).
module tb_score_sequencer;
   localparam int SCAN_DIV = 4, SCORE_MAX = 9999, LIVES = 3, FLASH_DIV = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1, gs = 1'b0, bh = 1'b0, bl = 1'b0;
   logic [3:0]  hp = 4'd0;
   logic [13:0] score, high;
   logic [1:0]  lives;
   logic        active, over, newh, tick, flash;
   int          n_vec = 0, n_err = 0;

   always #5 clk = ~clk;

   score_sequencer #(.SCAN_DIV(SCAN_DIV), .SCORE_MAX(SCORE_MAX), .LIVES(LIVES),
                     .FLASH_DIV(FLASH_DIV)) dut (
      .i_clk(clk), .i_reset(reset), .i_game_start(gs), .i_brick_hit(bh),
      .i_hit_points(hp), .i_ball_lost(bl), .o_current_score(score),
      .o_high_score(high), .o_lives_left(lives), .o_game_active(active),
      .o_game_over(over), .o_new_high(newh), .o_scan_tick(tick),
      .o_flash_blank(flash));

   // one clock with the given pulses, outputs sampled 1ns after the edge
   task automatic cyc(input logic g, input logic b, input logic [3:0] p, input logic l);
      gs = g; bh = b; hp = p; bl = l;
      @(posedge clk); #1;
      gs = 1'b0; bh = 1'b0; hp = 4'd0; bl = 1'b0;
   endtask

   task automatic do_reset;
      reset = 1'b1; cyc(0, 0, 0, 0); cyc(0, 0, 0, 0); reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1; cyc(1, 1, 15, 1); cyc(1, 1, 15, 1); reset = 1'b0;
      n_vec++;
      if ({score, high, lives, active, over, newh, tick, flash} !== {14'd0, 14'd0, 2'd3, 5'b0}) begin
         n_err++;
         $display("FAIL reset_values got score=%0d high=%0d lives=%0d act=%b over=%b nh=%b tick=%b fl=%b exp 0 0 3 0 0 0 0 0",
                  score, high, lives, active, over, newh, tick, flash);
      end
   endtask

   task automatic test_scan_tick;
      for (int j = 1; j <= 12; j++) begin
         logic exp;
         cyc(0, 0, 0, 0);
         exp = (j % 4 == 3);
         n_vec++;
         if (tick !== exp) begin
            n_err++;
            $display("FAIL scan_tick cycle=%0d got=%b exp=%b", j + 1, tick, exp);
         end
      end
   endtask

   task automatic test_scoring;
      logic [3:0]  pts [3] = '{4'd5, 4'd0, 4'd15};
      logic [13:0] exp [3] = '{14'd5, 14'd5, 14'd20};
      cyc(1, 0, 0, 0);
      n_vec++;
      if (active !== 1'b1 || score !== 14'd0 || lives !== 2'd3) begin
         n_err++;
         $display("FAIL start got act=%b score=%0d lives=%0d exp 1 0 3", active, score, lives);
      end
      for (int k = 0; k < 3; k++) begin
         cyc(0, 1, pts[k], 0);
         n_vec++;
         if (score !== exp[k] || lives !== 2'd3 || active !== 1'b1) begin
            n_err++;
            $display("FAIL hit%0d got score=%0d lives=%0d act=%b exp %0d 3 1", k, score, lives, active, exp[k]);
         end
      end
      cyc(1, 0, 0, 0);
      n_vec++;
      if (score !== 14'd20 || active !== 1'b1) begin
         n_err++;
         $display("FAIL start_in_play got score=%0d act=%b exp 20 1", score, active);
      end
   endtask

   task automatic test_saturation;
      do_reset();
      cyc(1, 0, 0, 0);
      bh = 1'b1; hp = 4'd15;
      repeat (666) @(posedge clk);
      #1; bh = 1'b0; hp = 4'd0;
      n_vec++;
      if (score !== 14'd9990) begin
         n_err++;
         $display("FAIL preload got=%0d exp=9990", score);
      end
      cyc(0, 1, 15, 0);
      n_vec++;
      if (score !== 14'd9999) begin
         n_err++;
         $display("FAIL clamp got=%0d exp=9999", score);
      end
      cyc(0, 1, 15, 0);
      n_vec++;
      if (score !== 14'd9999) begin
         n_err++;
         $display("FAIL clamp_hold got=%0d exp=9999", score);
      end
   endtask

   task automatic test_end_game;
      do_reset();
      cyc(1, 0, 0, 0);
      cyc(0, 1, 15, 0); cyc(0, 1, 15, 0); cyc(0, 1, 12, 0);
      n_vec++;
      if (score !== 14'd42) begin
         n_err++;
         $display("FAIL score42 got=%0d exp=42", score);
      end
      cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);
      n_vec++;
      if (lives !== 2'd1 || active !== 1'b1) begin
         n_err++;
         $display("FAIL two_lost got lives=%0d act=%b exp 1 1", lives, active);
      end
      cyc(0, 1, 8, 1);
      n_vec++;
      if ({score, lives, active, over, high, newh} !== {14'd50, 2'd0, 2'b00, 14'd0, 1'b0}) begin
         n_err++;
         $display("FAIL commit_cycle got score=%0d lives=%0d act=%b over=%b high=%0d nh=%b exp 50 0 0 0 0 0",
                  score, lives, active, over, high, newh);
      end
      cyc(0, 0, 0, 0);
      n_vec++;
      if (high !== 14'd50 || newh !== 1'b1 || over !== 1'b1 || active !== 1'b0) begin
         n_err++;
         $display("FAIL game_over got high=%0d nh=%b over=%b act=%b exp 50 1 1 0", high, newh, over, active);
      end
      cyc(0, 1, 9, 1);
      n_vec++;
      if (score !== 14'd50 || lives !== 2'd0 || over !== 1'b1) begin
         n_err++;
         $display("FAIL over_ignore got score=%0d lives=%0d over=%b exp 50 0 1", score, lives, over);
      end
   endtask

   task automatic test_flash;
`ifdef NEW_HIGH_FLASH_EN
      int wait_c = 0, per = 0;
      while (flash !== 1'b1 && wait_c < 20) begin cyc(0, 0, 0, 0); wait_c++; end
      n_vec++;
      if (flash !== 1'b1) begin
         n_err++;
         $display("FAIL flash_rise got=%b exp=1 within 20 cycles", flash);
      end
      while (flash === 1'b1 && per < 20) begin cyc(0, 0, 0, 0); per++; end
      n_vec++;
      if (per !== 8) begin
         n_err++;
         $display("FAIL flash_period got=%0d exp=8", per);
      end
`else
      logic seen = 1'b0;
      for (int k = 0; k < 20; k++) begin cyc(0, 0, 0, 0); seen = seen | flash; end
      n_vec++;
      if (seen !== 1'b0) begin
         n_err++;
         $display("FAIL flash_tied got=%b exp=0", seen);
      end
`endif
   endtask

   task automatic test_high_hold;
      cyc(1, 0, 0, 0);
      n_vec++;
      if ({score, high, newh, lives, active, flash} !== {14'd0, 14'd50, 1'b0, 2'd3, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL restart got score=%0d high=%0d nh=%b lives=%0d act=%b fl=%b exp 0 50 0 3 1 0",
                  score, high, newh, lives, active, flash);
      end
      cyc(0, 1, 15, 0); cyc(0, 1, 15, 0); cyc(0, 1, 15, 0); cyc(0, 1, 5, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      n_vec++;
      if (score !== 14'd50 || high !== 14'd50 || newh !== 1'b0 || over !== 1'b1) begin
         n_err++;
         $display("FAIL tie got score=%0d high=%0d nh=%b over=%b exp 50 50 0 1", score, high, newh, over);
      end
      cyc(1, 0, 0, 0);
      cyc(0, 1, 15, 0); cyc(0, 1, 15, 0);
      for (int k = 0; k < 3; k++) cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 0);
      n_vec++;
      if (score !== 14'd30 || high !== 14'd50 || newh !== 1'b0 || over !== 1'b1) begin
         n_err++;
         $display("FAIL lower got score=%0d high=%0d nh=%b over=%b exp 30 50 0 1", score, high, newh, over);
      end
   endtask

   task automatic test_reset_mid;
      cyc(1, 0, 0, 0); cyc(0, 1, 7, 0);
      n_vec++;
      if (score !== 14'd7) begin
         n_err++;
         $display("FAIL pre_reset got=%0d exp=7", score);
      end
      reset = 1'b1; cyc(0, 1, 3, 1); reset = 1'b0;
      n_vec++;
      if ({score, high, lives, active, over, newh} !== {14'd0, 14'd0, 2'd3, 3'b0}) begin
         n_err++;
         $display("FAIL reset_mid got score=%0d high=%0d lives=%0d act=%b over=%b nh=%b exp 0 0 3 0 0 0",
                  score, high, lives, active, over, newh);
      end
      cyc(0, 1, 3, 0);
      n_vec++;
      if (score !== 14'd0 || active !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ignore got score=%0d act=%b exp 0 0", score, active);
      end
   endtask

   initial begin
      test_reset();
      test_scan_tick();
      test_scoring();
      test_saturation();
      test_end_game();
      test_flash();
      test_high_hold();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/score_sequencer.md
# score_sequencer

Game-side controller that owns the two 14-bit binary scores shown on the 8-digit seven-segment display: current score on digits 0-3, high score on digits 4-7. It sequences a game (idle, play, high-score commit, game over) from brick-hit and ball-lost pulses, saturates the score at 9999 so the display's 4-digit BCD conversion never overflows, and generates the digit-scan enable strobe for the display multiplexer. It sits between the game logic and the seven-segment display FSM.

## Interface
- SCAN_DIV, 100000: clk cycles per scan_tick (1 kHz digit scan at 100 MHz).
- SCORE_MAX, 9999: saturation value of current_score; must be ≤ 9999.
- LIVES, 3: balls per game, 1..3.
- FLASH_DIV, 250: scan_ticks per flash_blank half-period.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high; clears all state including high_score.
- game_start  in  1  one-cycle pulse; starts or restarts a game.
- brick_hit  in  1  one-cycle pulse; award hit_points.
- hit_points  in  4  points for this hit, 0..15; sampled only with brick_hit.
- ball_lost  in  1  one-cycle pulse; consume one life.
- current_score  out  14  binary score of the running or last game.
- high_score  out  14  best score since reset.
- lives_left  out  2  remaining lives.
- game_active  out  1  high in PLAY.
- game_over  out  1  high in OVER.
- new_high  out  1  last game set a new high score.
- scan_tick  out  1  one-cycle digit-advance strobe for the display FSM.
- flash_blank  out  1  display blanking request.

## Operation
- States: IDLE, PLAY, COMMIT, OVER. Reset → IDLE.
- Reset values: current_score 0, high_score 0, lives_left LIVES, game_active 0, game_over 0, new_high 0, scan_tick 0, flash_blank 0.
- IDLE: game_start → PLAY; on the same edge current_score ← 0, lives_left ← LIVES, new_high ← 0.
- PLAY:
  - brick_hit: current_score ← min(current_score + hit_points, SCORE_MAX). The sum is computed at 15 bits before the clamp. hit_points = 0 leaves the score unchanged.
  - ball_lost: lives_left ← lives_left − 1. If lives_left was 1, the next state is COMMIT (lives_left becomes 0).
  - brick_hit and ball_lost on the same cycle: both apply on that edge. The hit is still scored even if it is the final ball.
  - game_start: ignored.
- COMMIT: lasts one cycle. If current_score > high_score, then high_score ← current_score and new_high ← 1. A tie does not update. Next state is OVER unconditionally. All inputs are ignored.
- OVER:
  - current_score and high_score hold.
  - game_start → PLAY with the same clears as from IDLE; high_score is retained.
  - brick_hit and ball_lost are ignored.
- Inputs are ignored in any state not listed above. A pulse held high for N cycles counts N times.
- scan_tick:
  - Free-running counter 0..SCAN_DIV−1 that runs in all states.
  - scan_tick = 1 during the cycle the counter equals SCAN_DIV−1; the counter wraps to 0 on the next edge.
  - reset clears the counter.

## Timing
- All outputs are registered. Score, lives and flag updates are visible the cycle after the input pulse.
- End of game: the final ball_lost at edge N makes state = COMMIT after edge N. high_score and new_high update at edge N+1, and game_over = 1 from edge N+1.
- The first scan_tick is asserted SCAN_DIV cycles after reset deasserts, then every SCAN_DIV cycles.
- reset mid-game takes priority over every input on that edge and returns the block to reset values.

## Configuration
- NEW_HIGH_FLASH_EN defined:
  - In OVER with new_high = 1, flash_blank toggles every FLASH_DIV scan_ticks. The flash counter starts at 0 on entry to OVER and flash_blank is 0 on entry.
  - flash_blank = 0 in all other states. Leaving OVER clears flash_blank and the flash counter.
- NEW_HIGH_FLASH_EN undefined: flash_blank is tied to 0 and no flash counter is built.

## Test plan
- Reset, game_start, then 3 brick_hits with hit_points 5, 0, 15 → current_score 20, lives_left 3, game_active 1.
- Preload score 9990, brick_hit with hit_points 15 → current_score 9999; a further brick_hit with 15 → still 9999.
- Score 42, then 3 ball_lost pulses with a brick_hit of 8 coincident with the third → score 50, lives_left 0, COMMIT, then high_score 50, new_high 1, game_over 1.
- Second game ending at 50, then a third ending at 30 → high_score stays 50 and new_high is 0 after both; game_start in OVER clears the score to 0 and keeps high_score 50.
- SCAN_DIV = 4 → scan_tick high on cycles 4, 8, 12 after reset release; a reset mid-PLAY zeroes high_score and returns to IDLE.
- With NEW_HIGH_FLASH_EN, FLASH_DIV = 2, SCAN_DIV = 4 → flash_blank toggles every 8 cycles in OVER after a new high and clears on game_start.
